// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 program loader: mnemonic codes, opcode
// nibbles and the loader state encoding.
package td4_pkg;

   // Symbolic mnemonic codes offered on in_mnem (12..15 are illegal).
   localparam logic [3:0] MN_ADD_A_IM = 4'd0;
   localparam logic [3:0] MN_MOV_A_B  = 4'd1;
   localparam logic [3:0] MN_IN_A     = 4'd2;
   localparam logic [3:0] MN_MOV_A_IM = 4'd3;
   localparam logic [3:0] MN_MOV_B_A  = 4'd4;
   localparam logic [3:0] MN_ADD_B_IM = 4'd5;
   localparam logic [3:0] MN_IN_B     = 4'd6;
   localparam logic [3:0] MN_MOV_B_IM = 4'd7;
   localparam logic [3:0] MN_OUT_B    = 4'd8;
   localparam logic [3:0] MN_OUT_IM   = 4'd9;
   localparam logic [3:0] MN_JNC      = 4'd10;
   localparam logic [3:0] MN_JMP      = 4'd11;

   // Upper opcode nibble of each TD4 instruction.
   localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
   localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
   localparam logic [3:0] OP_IN_A     = 4'b0010;
   localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
   localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
   localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
   localparam logic [3:0] OP_IN_B     = 4'b0110;
   localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
   localparam logic [3:0] OP_OUT_B    = 4'b1001;
   localparam logic [3:0] OP_OUT_IM   = 4'b1011;
   localparam logic [3:0] OP_JNC      = 4'b1110;
   localparam logic [3:0] OP_JMP      = 4'b1111;

   // Loader session state.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } td4_state_e;

endpackage

// File: rtl/td4_op_encoder.sv
// Combinational mnemonic -> TD4 opcode byte encoder. Register-only forms
// carry a zero immediate; codes 12..15 are flagged illegal.
module td4_op_encoder
   import td4_pkg::*;
(
   input  logic [3:0] mnem_i,
   input  logic [3:0] imm_i,
   output logic [7:0] op_o,
   output logic       illegal_o
);

   logic [3:0] hi_nib;
   logic       keep_imm;

   // Map the mnemonic onto its opcode nibble and decide whether the immediate survives.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      hi_nib    = OP_ADD_A_IM;
      keep_imm  = 1'b1;
      illegal_o = 1'b0;
      case (mnem_i)
         MN_ADD_A_IM: hi_nib = OP_ADD_A_IM;
         MN_MOV_A_B:  begin hi_nib = OP_MOV_A_B; keep_imm = 1'b0; end
         MN_IN_A:     begin hi_nib = OP_IN_A;    keep_imm = 1'b0; end
         MN_MOV_A_IM: hi_nib = OP_MOV_A_IM;
         MN_MOV_B_A:  begin hi_nib = OP_MOV_B_A; keep_imm = 1'b0; end
         MN_ADD_B_IM: hi_nib = OP_ADD_B_IM;
         MN_IN_B:     begin hi_nib = OP_IN_B;    keep_imm = 1'b0; end
         MN_MOV_B_IM: hi_nib = OP_MOV_B_IM;
         MN_OUT_B:    begin hi_nib = OP_OUT_B;   keep_imm = 1'b0; end
         MN_OUT_IM:   hi_nib = OP_OUT_IM;
         MN_JNC:      hi_nib = OP_JNC;
         MN_JMP:      hi_nib = OP_JMP;
         default: begin
            illegal_o = 1'b1;
            keep_imm  = 1'b0;
         end
      endcase
      op_o = {hi_nib, (keep_imm ? imm_i : 4'h0)};
   end

endmodule

// File: rtl/td4_program_loader.sv
// TD4 program loader: accepts symbolic instructions over valid/ready,
// encodes them into a 16-entry program store and serves a registered
// fetch port to the instruction decoder.
module td4_program_loader
   import td4_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_mnem,
   input  logic [3:0]        in_imm,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [7:0]        op,
   output logic [ADDR_W:0]   count,
   output logic              loading,
   output logic              full,
   output logic              err
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] COUNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

   td4_state_e      state_q, state_d;
   logic [ADDR_W:0] count_q, count_d;
   logic            err_q, err_d;
   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      op_q;

   logic [7:0]      enc_op;
   logic            illegal;
   logic            xfer;
   logic            wr_en;

   td4_op_encoder u_enc (
      .mnem_i    (in_mnem),
      .imm_i     (in_imm),
      .op_o      (enc_op),
      .illegal_o (illegal)
   );

   // A new start pre-empts any handshake offered in the same cycle.
   assign full     = (count_q == COUNT_FULL);
   assign loading  = (state_q == ST_LOAD);
   assign in_ready = loading && !full && !start;
   assign xfer     = in_valid && in_ready;
   assign wr_en    = xfer && !illegal;

   assign count = count_q;
   assign err   = err_q;
   assign op    = op_q;

   // Next-state, count and error-flag logic for the load session.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      err_d   = err_q;
      if (start) begin
         state_d = ST_LOAD;
         count_d = '0;
         err_d   = 1'b0;
      end else begin
         if (wr_en) count_d = count_q + 1'b1;
         if (xfer && illegal) err_d = 1'b1;
         if (state_q == ST_LOAD && (finish || (wr_en && count_q == COUNT_LAST)))
            state_d = ST_DONE;
      end
   end

   // Session state registers.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Program store write on handshake, plus the registered fetch port.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: the store is built from flops and cleared on reset, so a reset mid-session leaves no stale bytes.
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
         op_q <= 8'h00;
      end else begin
         if (wr_en) mem_q[count_q[ADDR_W-1:0]] <= enc_op;
         // Reading the pre-edge contents gives old data on a same-address write.
         op_q <= mem_q[fetch_addr];
      end
   end

endmodule

// File: tb/tb_td4_program_loader.sv
// Directed self-checking bench for td4_program_loader.
module tb_td4_program_loader;

   logic       clk;
   logic       reset;
   logic       start;
   logic       finish;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_mnem;
   logic [3:0] in_imm;
   logic [3:0] fetch_addr;
   logic [7:0] op;
   logic [4:0] count;
   logic       loading;
   logic       full;
   logic       err;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   td4_program_loader #(.ADDR_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .finish     (finish),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mnem    (in_mnem),
      .in_imm     (in_imm),
      .fetch_addr (fetch_addr),
      .op         (op),
      .count      (count),
      .loading    (loading),
      .full       (full),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an address, let one edge capture it, check op.
   task automatic fetch_check(input string tag, input logic [3:0] addr, input logic [7:0] exp);
      fetch_addr = addr;
      step();
      check(tag, {8'h00, op}, {8'h00, exp});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   logic [7:0] full_exp [16];
   logic [3:0] full_mn  [16];

   initial begin
      full_mn  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                   4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd1, 4'd2, 4'd3};
      full_exp = '{8'h00, 8'h10, 8'h20, 8'h33, 8'h40, 8'h55, 8'h60, 8'h77,
                   8'h90, 8'hB9, 8'hEA, 8'hFB, 8'h0C, 8'h10, 8'h20, 8'h3F};

      reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
      in_mnem = 4'd0; in_imm = 4'd0; fetch_addr = 4'd0;

      // ---- Reset state ----
      step();
      check("rst_op", {8'h00, op}, 16'h0000);
      check("rst_count", {11'd0, count}, 16'd0);
      check("rst_err", {15'd0, err}, 16'd0);
      check("rst_in_ready", {15'd0, in_ready}, 16'd0);
      check("rst_loading", {15'd0, loading}, 16'd0);
      check("rst_full", {15'd0, full}, 16'd0);
      #2 reset = 1'b0;
      for (int a = 0; a < 16; a++) fetch_check($sformatf("rst_fetch%0d", a), 4'(a), 8'h00);
      check("idle_in_ready", {15'd0, in_ready}, 16'd0);

      // ---- Four-instruction session ended by finish ----
      start = 1'b1;
      #1 check("start_blocks_ready", {15'd0, in_ready}, 16'd0);
      step();
      start = 1'b0;
      check("s1_loading", {15'd0, loading}, 16'd1);
      check("s1_count0", {11'd0, count}, 16'd0);
      in_valid = 1'b1; in_mnem = 4'd3; in_imm = 4'd3;
      #1 check("s1_in_ready", {15'd0, in_ready}, 16'd1);
      step();
      in_mnem = 4'd0; in_imm = 4'd1; step();
      in_mnem = 4'd8; in_imm = 4'd7; step();
      in_mnem = 4'd11; in_imm = 4'd2; step();
      in_valid = 1'b0;
      check("s1_count4", {11'd0, count}, 16'd4);
      check("s1_still_load", {15'd0, loading}, 16'd1);
      finish = 1'b1; step(); finish = 1'b0;
      check("s1_done", {15'd0, loading}, 16'd0);
      check("s1_done_ready", {15'd0, in_ready}, 16'd0);
      check("s1_count_kept", {11'd0, count}, 16'd4);
      fetch_check("s1_mem0", 4'd0, 8'h33);
      fetch_check("s1_mem1", 4'd1, 8'h01);
      fetch_check("s1_mem2", 4'd2, 8'h90);
      fetch_check("s1_mem3", 4'd3, 8'hF2);

      // ---- Sixteen back-to-back handshakes ----
      pulse_start();
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_mnem = full_mn[i];
         in_imm  = 4'(i);
         step();
         if (i == 14) begin
            check("s2_count15", {11'd0, count}, 16'd15);
            check("s2_not_full15", {15'd0, full}, 16'd0);
         end
      end
      check("s2_full", {15'd0, full}, 16'd1);
      check("s2_count16", {11'd0, count}, 16'd16);
      check("s2_ready_low", {15'd0, in_ready}, 16'd0);
      check("s2_done", {15'd0, loading}, 16'd0);
      in_mnem = 4'd7; in_imm = 4'd1; step();
      in_valid = 1'b0;
      check("s2_no_17th", {11'd0, count}, 16'd16);
      for (int a = 0; a < 16; a++) fetch_check($sformatf("s2_mem%0d", a), 4'(a), full_exp[a]);

      // ---- Illegal mnemonic ----
      pulse_start();
      in_valid = 1'b1; in_mnem = 4'd7; in_imm = 4'd4; step();
      in_mnem = 4'd13; in_imm = 4'd5; step();
      in_valid = 1'b0;
      check("s3_err", {15'd0, err}, 16'd1);
      check("s3_count", {11'd0, count}, 16'd1);
      check("s3_still_ready", {15'd0, in_ready}, 16'd1);
      fetch_check("s3_mem0", 4'd0, 8'h74);
      fetch_check("s3_mem1_untouched", 4'd1, 8'h10);
      pulse_start();
      check("s3_err_cleared", {15'd0, err}, 16'd0);
      check("s3_count_cleared", {11'd0, count}, 16'd0);

      // ---- Handshake with finish; start during valid ----
      in_valid = 1'b1; in_mnem = 4'd9; in_imm = 4'd6; finish = 1'b1;
      step();
      in_valid = 1'b0; finish = 1'b0;
      check("s4_fin_done", {15'd0, loading}, 16'd0);
      check("s4_fin_count", {11'd0, count}, 16'd1);
      fetch_check("s4_fin_mem0", 4'd0, 8'hB6);
      pulse_start();
      in_valid = 1'b1; in_mnem = 4'd3; in_imm = 4'd1; start = 1'b1;
      #1 check("s4_start_ready", {15'd0, in_ready}, 16'd0);
      step();
      start = 1'b0; in_valid = 1'b0;
      check("s4_start_count", {11'd0, count}, 16'd0);
      check("s4_start_loading", {15'd0, loading}, 16'd1);
      fetch_check("s4_start_mem0", 4'd0, 8'hB6);

      // ---- Reset mid-session ----
      in_valid = 1'b1;
      in_mnem = 4'd3; in_imm = 4'd5; step();
      in_mnem = 4'd7; in_imm = 4'd2; step();
      in_mnem = 4'd11; in_imm = 4'd0; step();
      in_mnem = 4'd14; in_imm = 4'd0; step();
      in_valid = 1'b0;
      check("s5_count3", {11'd0, count}, 16'd3);
      check("s5_err", {15'd0, err}, 16'd1);
      fetch_check("s5_mem1", 4'd1, 8'h72);
      reset = 1'b1;
      #2;
      check("s5_rst_op", {8'h00, op}, 16'h0000);
      check("s5_rst_count", {11'd0, count}, 16'd0);
      check("s5_rst_err", {15'd0, err}, 16'd0);
      check("s5_rst_loading", {15'd0, loading}, 16'd0);
      check("s5_rst_full", {15'd0, full}, 16'd0);
      check("s5_rst_ready", {15'd0, in_ready}, 16'd0);
      #1 reset = 1'b0;
      for (int a = 0; a < 16; a++) fetch_check($sformatf("s5_mem%0d", a), 4'(a), 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
